// File: rtl/command_decoder_pkg.sv
// Shared types for the byte-stream command decoder: opcodes, length table,
// error codes and FSM states.
package command_pkg;

    typedef enum logic [7:0] {
        OP_NOP       = 8'h00,
        OP_WRITE_REG = 8'h01,
        OP_DRAW      = 8'h02,
        OP_SET_COLOR = 8'h03
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNKNOWN  = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_CHECKSUM = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_HOLD
    } state_e;

    function automatic logic op_known(input logic [7:0] op);
        return op <= OP_SET_COLOR;
    endfunction

    function automatic logic [3:0] op_len(input logic [7:0] op);
        logic [3:0] len;
        len = 4'd0;
        case (op)
            OP_WRITE_REG: len = 4'd2;
            OP_DRAW:      len = 4'd8;
            OP_SET_COLOR: len = 4'd3;
            default:      len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/command_decoder_if.sv
// FIFO-read and command-output bundle of the command decoder.
interface command_decoder_if #(
    parameter int MAX_PAYLOAD = 8
);
    logic                     fifo_read_ready;
    logic [7:0]               fifo_data;
    logic                     fifo_read_en;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [7:0]               cmd_opcode;
    logic [8*MAX_PAYLOAD-1:0] cmd_payload;
    logic                     error;
    logic [1:0]               error_code;

    modport master (
        input  fifo_read_ready, fifo_data, cmd_ready,
        output fifo_read_en, cmd_valid, cmd_opcode,
        output cmd_payload, error, error_code
    );

    modport slave (
        output fifo_read_ready, fifo_data, cmd_ready,
        input  fifo_read_en, cmd_valid, cmd_opcode,
        input  cmd_payload, error, error_code
    );
endinterface

// File: rtl/command_decoder_idle_timer.sv
// Saturating idle counter; expired fires on the cycle the count would
// reach LIMIT. LIMIT = 0 disables it.
module IdleTimer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 2);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != W'(LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (LIMIT != 0) && enable
                     && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/command_decoder.sv
// Frames FIFO bytes into opcode+payload commands on a valid/ready port.
// COMMAND_DECODER_CHECKSUM_EN adds a trailing XOR checksum byte.
module command_decoder
    import command_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               rstn,
    command_decoder_if.master bus
);
    localparam int IW = $clog2(MAX_PAYLOAD + 1);

`ifdef COMMAND_DECODER_CHECKSUM_EN
    localparam state_e S_DONE = S_CHECK;
`else
    localparam state_e S_DONE = S_HOLD;
`endif

    state_e                   state, state_n;
    logic [7:0]               opcode_q;
    logic [8*MAX_PAYLOAD-1:0] payload_q;
    logic [IW-1:0]            idx_q;
    logic                     err_q, err_n;
    logic [1:0]               code_q, code_n;
    logic                     rd_en, pop;
    logic                     last_byte, expired;
    logic                     tmr_clear, tmr_en;

    assign pop = bus.fifo_read_en & bus.fifo_read_ready;
    assign last_byte =
        (int'(idx_q) + 1 == int'(op_len(opcode_q)));

`ifdef COMMAND_DECODER_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = opcode_q;
        for (int i = 0; i < MAX_PAYLOAD; i++)
            csum ^= payload_q[8*i +: 8];
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        err_n   = 1'b0;
        code_n  = ERR_NONE;
        unique case (state)
            S_IDLE: begin
                rd_en = bus.fifo_read_ready;
                if (pop) begin
                    if (!op_known(bus.fifo_data)) begin
                        err_n  = 1'b1;
                        code_n = ERR_UNKNOWN;
                    end else if (op_len(bus.fifo_data) == 4'd0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                rd_en = bus.fifo_read_ready;
                if (pop && last_byte) begin
                    state_n = S_DONE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = S_IDLE;
                end
            end
            S_CHECK: begin
`ifdef COMMAND_DECODER_CHECKSUM_EN
                rd_en = bus.fifo_read_ready;
                if (pop) begin
                    if (bus.fifo_data == csum) begin
                        state_n = S_HOLD;
                    end else begin
                        err_n   = 1'b1;
                        code_n  = ERR_CHECKSUM;
                        state_n = S_IDLE;
                    end
                end else if (expired) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = S_IDLE;
                end
`else
                state_n = S_IDLE;
`endif
            end
            S_HOLD: begin
                if (bus.cmd_ready) state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opcode_q  <= '0;
            payload_q <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            err_q <= err_n;
            if (err_n) code_q <= code_n;
            if (state == S_IDLE && pop) begin
                opcode_q  <= bus.fifo_data;
                payload_q <= '0;
                idx_q     <= '0;
            end
            if (state == S_PAYLOAD && pop) begin
                for (int i = 0; i < MAX_PAYLOAD; i++)
                    if (int'(idx_q) == i)
                        payload_q[8*i +: 8] <= bus.fifo_data;
                if (idx_q != IW'(MAX_PAYLOAD))
                    idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Only PAYLOAD and CHECK wait on the FIFO, so only they age.
    assign tmr_clear = pop || state == S_IDLE
                       || state == S_HOLD;
    assign tmr_en = !pop && (state == S_PAYLOAD
                             || state == S_CHECK);

    IdleTimer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (expired)
    );

    // Gated by rstn so nothing is popped while reset is held.
    assign bus.fifo_read_en = rd_en & rstn;
    assign bus.cmd_valid    = (state == S_HOLD);
    assign bus.cmd_opcode   = opcode_q;
    assign bus.cmd_payload  = payload_q;
    assign bus.error        = err_q;
    assign bus.error_code   = code_q;
endmodule

// File: tb/tb_command_decoder.sv
// Randomized bench for command_decoder against a command-level model.
// Honours COMMAND_DECODER_CHECKSUM_EN.
module tb_command_decoder;
    localparam int MP = 8;
    localparam int TO = 40;
`ifdef COMMAND_DECODER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    typedef struct {
        bit          is_cmd;
        logic [1:0]  code;
        logic [7:0]  op;
        logic [63:0] pl;
    } ev_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    command_decoder_if #(.MAX_PAYLOAD(MP)) bus ();

    command_decoder #(
        .MAX_PAYLOAD    (MP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] fifo_q[$];
    int         tag_q[$];
    ev_t        evq[$];
    int  cyc = 0;
    int  last_pop_cyc = 0;
    int  err_cyc = -1;
    bit  exp_valid = 0;
    bit  exp_err = 0;
    bit  avail = 1;
    int  gap = 0;
    int  avail_mode = 1;
    int  ready_mode = 2;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int len_of(input logic [7:0] op);
        case (op)
            8'h00:   return 0;
            8'h01:   return 2;
            8'h02:   return 8;
            8'h03:   return 3;
            default: return -1;
        endcase
    endfunction

    // Tags: 1 = completes a command, 2 = triggers an error.
    task automatic push_byte(input logic [7:0] b, input int t);
        fifo_q.push_back(b);
        tag_q.push_back(t);
    endtask

    task automatic push_cmd(input logic [7:0] op,
                            input logic [63:0] pl);
        int n;
        ev_t e;
        logic [7:0] x;
        n = len_of(op);
        x = op;
        e.op = op;
        e.pl = '0;
        e.code = 2'd0;
        if (n < 0) begin
            push_byte(op, 2);
            e.is_cmd = 0;
            e.code = 2'd1;
        end else begin
            push_byte(op, (n == 0 && !CS) ? 1 : 0);
            for (int i = 0; i < n; i++) begin
                push_byte(pl[8*i +: 8],
                          (i == n - 1 && !CS) ? 1 : 0);
                e.pl[8*i +: 8] = pl[8*i +: 8];
                x ^= pl[8*i +: 8];
            end
            if (CS) push_byte(x, 1);
            e.is_cmd = 1;
        end
        evq.push_back(e);
    endtask

    task automatic drive();
        if (avail_mode == 0) begin
            avail = ($urandom_range(0, 99) < 70) || gap >= 3;
            gap = avail ? 0 : gap + 1;
        end else begin
            avail = 1;
        end
        bus.fifo_read_ready = avail && fifo_q.size() > 0;
        bus.fifo_data = fifo_q.size() > 0 ? fifo_q[0] : 8'h00;
        case (ready_mode)
            0:       bus.cmd_ready = $urandom_range(0, 1);
            1:       bus.cmd_ready = 1'b0;
            default: bus.cmd_ready = 1'b1;
        endcase
    endtask

    task automatic step();
        bit pop_pend;
        int t;
        cyc++;
        @(negedge clk);
        if (exp_valid) check("valid_lat", bus.cmd_valid, 1);
        if (exp_err) check("err_lat", bus.error, 1);
        if (bus.error) begin
            if (evq.size() == 0 || evq[0].is_cmd) begin
                check("err_spurious", bus.error, 0);
            end else begin
                check("err_code", bus.error_code, evq[0].code);
                void'(evq.pop_front());
                err_cyc = cyc;
            end
        end
        if (bus.cmd_valid) begin
            check("hold_rden", bus.fifo_read_en, 0);
            if (evq.size() == 0 || !evq[0].is_cmd) begin
                check("valid_spurious", bus.cmd_valid, 0);
            end else begin
                check("opcode", bus.cmd_opcode, evq[0].op);
                check("payload", bus.cmd_payload, evq[0].pl);
                if (bus.cmd_ready) void'(evq.pop_front());
            end
        end
        pop_pend = bus.fifo_read_en && bus.fifo_read_ready;
        @(posedge clk);
        #1;
        exp_valid = 0;
        exp_err = 0;
        if (pop_pend) begin
            void'(fifo_q.pop_front());
            t = tag_q.pop_front();
            exp_valid = (t == 1);
            exp_err = (t == 2);
            last_pop_cyc = cyc;
        end
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        drive();
        while ((fifo_q.size() > 0 || evq.size() > 0
                || bus.cmd_valid) && n < budget) begin
            step();
            n++;
        end
        check(tag, evq.size() + fifo_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rden"}, bus.fifo_read_en, 0);
        check({tag, "_valid"}, bus.cmd_valid, 0);
        check({tag, "_op"}, bus.cmd_opcode, 0);
        check({tag, "_pl"}, bus.cmd_payload, 0);
        check({tag, "_err"}, bus.error, 0);
        check({tag, "_code"}, bus.error_code, 0);
    endtask

    initial begin
        bus.fifo_read_ready = 1'b1;
        bus.fifo_data = 8'h01;
        bus.cmd_ready = 1'b0;
        #12;
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive();

        push_cmd(8'h01, 64'hCDAB);
        drain("wr_reg", 50);
        push_cmd(8'h00, 64'h0);
        push_cmd(8'h00, 64'h0);
        drain("nop_nop", 50);
        push_cmd(8'h7F, 64'h0);
        push_cmd(8'h00, 64'h0);
        drain("unk_nop", 50);

        ready_mode = 1;
        push_cmd(8'h02, 64'h8877665544332211);
        push_cmd(8'h01, 64'h5AA5);
        drive();
        for (int i = 0; i < 40 && !bus.cmd_valid; i++) step();
        for (int i = 0; i < 10; i++) step();
        check("stall_valid", bus.cmd_valid, 1);
        ready_mode = 2;
        drain("stall_drain", 50);

`ifdef COMMAND_DECODER_CHECKSUM_EN
        push_byte(8'h01, 0);
        push_byte(8'h12, 0);
        push_byte(8'h34, 0);
        push_byte(8'h27, 1);
        evq.push_back('{1, 2'd0, 8'h01, 64'h3412});
        push_byte(8'h01, 0);
        push_byte(8'h12, 0);
        push_byte(8'h34, 0);
        push_byte(8'h26, 2);
        evq.push_back('{0, 2'd3, 8'h00, 64'h0});
        drain("csum", 50);
`endif

        push_byte(8'h02, 0);
        push_byte(8'h11, 0);
        push_byte(8'h22, 0);
        push_byte(8'h33, 0);
        evq.push_back('{0, 2'd2, 8'h00, 64'h0});
        err_cyc = -1;
        drain("timeout", 3 * TO);
        check("timeout_lat", err_cyc - last_pop_cyc, TO + 1);
        push_cmd(8'h00, 64'h0);
        drain("post_to_nop", 50);

        push_byte(8'h02, 0);
        push_byte(8'h44, 0);
        push_byte(8'h55, 0);
        drive();
        for (int i = 0; i < 5; i++) step();
        #2;
        rstn = 1'b0;
        fifo_q.delete();
        tag_q.delete();
        evq.delete();
        exp_valid = 0;
        exp_err = 0;
        push_cmd(8'h00, 64'h0);
        drive();
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drain("post_rst_nop", 50);

        avail_mode = 0;
        ready_mode = 0;
        for (int k = 0; k < 200; k++) begin
            logic [7:0] op;
            if ($urandom_range(0, 99) < 85)
                op = 8'($urandom_range(0, 3));
            else
                op = 8'($urandom_range(4, 255));
            push_cmd(op, {$urandom, $urandom});
        end
        drain("random", 20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
